hazard_controller: RTL and testbench

- Pipeline control block for the 5-stage MIPS core (IF, ID, EX, MEM, WB). It inspects the decoded ID-stage instruction_t and tracks its own shadow copies of EX/MEM destination registers.
- It generates stall, bubble and fetch-flush controls for load-use and ID-resolved branch hazards.
- It runs the SYSCALL drain/halt sequence.
- It sits beside the Decoder and drives the IF/ID and ID/EX pipeline-register enables.

---
 rtl/pipeline_control_pkg.sv | 53 +++++
 rtl/operand_classifier.sv | 69 ++++++
 rtl/hazard_controller.sv | 106 ++++++++++
 tb/tb_hazard_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared pipeline-control types: decoded instruction layout, operand usage summary,
// hazard FSM states and the register-match helper.
package pipeline_control_pkg;

  typedef logic [4:0] register_id_t;
  typedef logic [5:0] operation_code_t;
  typedef logic [5:0] function_code_t;

  typedef struct packed {
    operation_code_t opcode;
    function_code_t  funct;
    register_id_t    rs;
    register_id_t    rt;
    register_id_t    rd;
    logic [4:0]      shamt;
    logic [15:0]     immediate;
    logic [25:0]     target;
  } instruction_t;

  localparam operation_code_t OP_SPECIAL = 6'h00;
  localparam operation_code_t OP_JAL     = 6'h03;
  localparam operation_code_t OP_BEQ     = 6'h04;
  localparam operation_code_t OP_BNE     = 6'h05;
  localparam operation_code_t OP_ORI     = 6'h0D;
  localparam operation_code_t OP_LUI     = 6'h0F;
  localparam operation_code_t OP_LW      = 6'h23;
  localparam operation_code_t OP_SW      = 6'h2B;

  localparam function_code_t FN_JR      = 6'h08;
  localparam function_code_t FN_SYSCALL = 6'h0C;
  localparam function_code_t FN_ADDU    = 6'h21;
  localparam function_code_t FN_SUBU    = 6'h23;

  localparam register_id_t REG_NONE = 5'd0;

  typedef struct packed {
    logic         reads_rs;
    logic         reads_rt;
    register_id_t dest;
    logic         is_load;
    logic         is_branch_or_jr;
    logic         is_jump;
    logic         is_syscall;
  } operand_use_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} hazard_state_t;

  // Register 0 is hard-wired, so it can never carry a dependency.
  function automatic logic src_match(logic reads, register_id_t src, register_id_t dest);
    return reads && (src != REG_NONE) && (src == dest);
  endfunction

endpackage

// File: rtl/operand_classifier.sv
// Combinational decode of a decoded instruction into the registers it reads/writes
// and the control-flow class the hazard logic cares about.
module operand_classifier
  import pipeline_control_pkg::*;
#(
  parameter int LINK_REGISTER = 31
) (
  input  instruction_t i_instruction,
  output operand_use_t o_use
);

  operand_use_t w_use;
  logic         w_unused_bits;

  assign w_unused_bits = ^{i_instruction.shamt, i_instruction.immediate, i_instruction.target};

  always_comb begin
    w_use = '0;
    case (i_instruction.opcode)
      OP_SPECIAL: begin
        case (i_instruction.funct)
          FN_ADDU, FN_SUBU: begin
            w_use.reads_rs = 1'b1;
            w_use.reads_rt = 1'b1;
            w_use.dest     = i_instruction.rd;
          end
          FN_JR: begin
            w_use.reads_rs        = 1'b1;
            w_use.is_branch_or_jr = 1'b1;
            w_use.is_jump         = 1'b1;
          end
          FN_SYSCALL: w_use.is_syscall = 1'b1;
          default: ;
        endcase
      end
      OP_ORI: begin
        w_use.reads_rs = 1'b1;
        w_use.dest     = i_instruction.rt;
      end
      OP_LUI: w_use.dest = i_instruction.rt;
      OP_LW: begin
        w_use.reads_rs = 1'b1;
        w_use.dest     = i_instruction.rt;
        w_use.is_load  = 1'b1;
      end
      OP_SW: begin
        w_use.reads_rs = 1'b1;
        w_use.reads_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_use.reads_rs        = 1'b1;
        w_use.reads_rt        = 1'b1;
        w_use.is_branch_or_jr = 1'b1;
      end
      OP_JAL: begin
        w_use.dest    = register_id_t'(LINK_REGISTER);
        w_use.is_jump = 1'b1;
      end
      default: ;
    endcase
    // A write to $0 is discarded, so it is no producer at all.
    if (w_use.dest == REG_NONE) begin
      w_use.is_load = 1'b0;
    end
  end

  assign o_use = w_use;

endmodule

// File: rtl/hazard_controller.sv
// Load-use / ID-branch hazard detection, fetch flush and SYSCALL drain/halt FSM
// for the 5-stage core; drives the IF/ID and ID/EX register controls.
module hazard_controller
  import pipeline_control_pkg::*;
#(
  parameter int DRAIN_CYCLES  = 3,
  parameter int LINK_REGISTER = 31
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         id_valid,
  input  instruction_t id_instruction,
  input  logic         branch_taken,
  output logic         stall,
  output logic         bubble_ex,
  output logic         flush_if,
  output logic         draining,
  output logic         halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hazard_state_t      r_state;
  logic [CNT_W-1:0]   r_count;
  register_id_t       r_ex_dest;
  logic               r_ex_is_load;
  register_id_t       r_mem_dest;
  logic               r_mem_is_load;

  operand_use_t w_use;
  logic         w_run;
  logic         w_ex_hit;
  logic         w_mem_hit;
  logic         w_hazard;
  logic         w_advance;
  logic         w_redirect;

  operand_classifier #(
    .LINK_REGISTER(LINK_REGISTER)
  ) u_id_classifier (
    .i_instruction(id_instruction),
    .o_use        (w_use)
  );

  assign w_run     = (r_state == RUN);
  assign w_ex_hit  = src_match(w_use.reads_rs, id_instruction.rs, r_ex_dest)
                   | src_match(w_use.reads_rt, id_instruction.rt, r_ex_dest);
  assign w_mem_hit = src_match(w_use.reads_rs, id_instruction.rs, r_mem_dest)
                   | src_match(w_use.reads_rt, id_instruction.rt, r_mem_dest);

  // Branches resolve in ID, so they also wait for ALU results in EX and loads in MEM.
  assign w_hazard = id_valid && w_run &&
                    ((w_ex_hit && r_ex_is_load) ||
                     (w_use.is_branch_or_jr && w_ex_hit && !r_ex_is_load) ||
                     (w_use.is_branch_or_jr && w_mem_hit && r_mem_is_load));

  assign w_advance  = id_valid && w_run && !w_hazard;
  assign w_redirect = w_use.is_jump || w_use.is_syscall ||
                      (w_use.is_branch_or_jr && branch_taken);

  assign stall     = reset_n && (w_hazard || !w_run);
  assign bubble_ex = reset_n && (w_hazard || !w_run);
  assign flush_if  = reset_n && w_advance && w_redirect;
  assign draining  = reset_n && (r_state == DRAIN);
  assign halted    = reset_n && (r_state == HALTED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_count       <= '0;
      r_ex_dest     <= REG_NONE;
      r_ex_is_load  <= 1'b0;
      r_mem_dest    <= REG_NONE;
      r_mem_is_load <= 1'b0;
    end else begin
      r_mem_dest    <= r_ex_dest;
      r_mem_is_load <= r_ex_is_load;
      if (w_advance) begin
        r_ex_dest    <= w_use.dest;
        r_ex_is_load <= w_use.is_load;
      end else begin
        r_ex_dest    <= REG_NONE;
        r_ex_is_load <= 1'b0;
      end

      case (r_state)
        RUN: begin
          if (w_advance && w_use.is_syscall) begin
            r_state <= DRAIN;
            r_count <= CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (r_count == '0) begin
            r_state <= HALTED;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table through a scoreboard,
// plus SYSCALL drain/halt and asynchronous reset sequences.
module tb_hazard_controller;
  import pipeline_control_pkg::*;

  logic         clock;
  logic         reset_n;
  logic         id_valid;
  instruction_t id_instruction;
  logic         branch_taken;
  logic         stall, bubble_ex, flush_if, draining, halted;

  hazard_controller #(
    .DRAIN_CYCLES (3),
    .LINK_REGISTER(31)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .id_valid      (id_valid),
    .id_instruction(id_instruction),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .bubble_ex     (bubble_ex),
    .flush_if      (flush_if),
    .draining      (draining),
    .halted        (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // expected output bits: {stall, bubble_ex, flush_if, draining, halted}
  localparam logic [4:0] E_NONE  = 5'b00000;
  localparam logic [4:0] E_STALL = 5'b11000;
  localparam logic [4:0] E_FLUSH = 5'b00100;
  localparam logic [4:0] E_DRAIN = 5'b11010;
  localparam logic [4:0] E_HALT  = 5'b11001;

  typedef struct {
    logic         valid;
    instruction_t ins;
    logic         taken;
    logic [4:0]   exp;
    string        tag;
  } vec_t;

  typedef struct {
    logic [4:0] exp;
    string      tag;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic instruction_t r_type(function_code_t fn, int rs, int rt, int rd);
    instruction_t i;
    i        = '0;
    i.opcode = OP_SPECIAL;
    i.funct  = fn;
    i.rs     = register_id_t'(rs);
    i.rt     = register_id_t'(rt);
    i.rd     = register_id_t'(rd);
    return i;
  endfunction

  function automatic instruction_t i_type(operation_code_t op, int rs, int rt, int imm);
    instruction_t i;
    i           = '0;
    i.opcode    = op;
    i.rs        = register_id_t'(rs);
    i.rt        = register_id_t'(rt);
    i.immediate = 16'(imm);
    return i;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [4:0] exp);
    check({tag, ".stall"},     stall,     exp[4]);
    check({tag, ".bubble_ex"}, bubble_ex, exp[3]);
    check({tag, ".flush_if"},  flush_if,  exp[2]);
    check({tag, ".draining"},  draining,  exp[1]);
    check({tag, ".halted"},    halted,    exp[0]);
  endtask

  task automatic add(input logic v, input instruction_t ins, input logic tk,
                     input logic [4:0] exp, input string tag);
    vec_t e;
    e.valid = v; e.ins = ins; e.taken = tk; e.exp = exp; e.tag = tag;
    vecs.push_back(e);
  endtask

  // Drive one ID cycle after the edge, queue its expectation, compare mid-cycle.
  task automatic step(input logic v, input instruction_t ins, input logic tk,
                      input logic [4:0] exp, input string tag);
    sb_t s;
    @(posedge clock);
    #1;
    id_valid       = v;
    id_instruction = ins;
    branch_taken   = tk;
    s.exp = exp; s.tag = tag;
    sb.push_back(s);
    @(negedge clock);
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 1'b1, 1'b0);
    end else begin
      s = sb.pop_front();
      check_all(s.tag, s.exp);
      $display("cycle %s: stall=%0b bubble=%0b flush=%0b drain=%0b halt=%0b",
               s.tag, stall, bubble_ex, flush_if, draining, halted);
    end
  endtask

  instruction_t jal_i, sys_i, lw8_i, addu10_i;

  initial begin
    jal_i    = i_type(OP_JAL, 0, 0, 0);
    sys_i    = r_type(FN_SYSCALL, 0, 0, 0);
    lw8_i    = i_type(OP_LW, 9, 8, 0);
    addu10_i = r_type(FN_ADDU, 8, 11, 10);

    // Reset asserted with a valid JAL in ID: every output must still read 0.
    reset_n        = 1'b0;
    id_valid       = 1'b1;
    id_instruction = jal_i;
    branch_taken   = 1'b1;
    #12;
    check_all("reset", E_NONE);
    id_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    add(1, lw8_i,                               0, E_NONE,  "lw8");
    add(1, addu10_i,                            0, E_STALL, "addu_after_lw");
    add(1, addu10_i,                            0, E_NONE,  "addu_proceeds");
    add(1, lw8_i,                               0, E_NONE,  "lw8_again");
    add(1, i_type(OP_BEQ, 8, 0, 4),             1, E_STALL, "beq_lw_stall1");
    add(1, i_type(OP_BEQ, 8, 0, 4),             1, E_STALL, "beq_lw_stall2");
    add(1, i_type(OP_BEQ, 8, 0, 4),             1, E_FLUSH, "beq_taken");
    add(0, '0,                                  0, E_NONE,  "squashed");
    add(1, r_type(FN_ADDU, 1, 2, 3),            0, E_NONE,  "addu3");
    add(1, i_type(OP_BNE, 3, 4, 4),             1, E_STALL, "bne_alu_stall");
    add(1, i_type(OP_BNE, 3, 4, 4),             1, E_FLUSH, "bne_taken");
    add(1, i_type(OP_ORI, 1, 0, 5),             0, E_NONE,  "ori_r0");
    add(1, i_type(OP_LW, 0, 2, 0),              0, E_NONE,  "lw_base_r0");
    add(1, i_type(OP_BEQ, 0, 0, 4),             1, E_FLUSH, "beq_r0_taken");
    add(1, i_type(OP_BEQ, 2, 0, 4),             1, E_STALL, "beq_mem_load_prio");
    add(1, i_type(OP_BEQ, 2, 0, 4),             0, E_NONE,  "beq_not_taken");
    add(1, jal_i,                               0, E_FLUSH, "jal");
    add(1, r_type(FN_JR, 31, 0, 0),             0, E_STALL, "jr_after_jal");
    add(1, r_type(FN_JR, 31, 0, 0),             0, E_FLUSH, "jr");
    add(1, i_type(6'h3F, 8, 8, 0),              1, E_NONE,  "unknown_op");
    add(0, jal_i,                               1, E_NONE,  "invalid_jal");
    add(1, i_type(OP_LW, 1, 5, 0),              0, E_NONE,  "lw5");
    add(1, i_type(OP_SW, 5, 7, 0),              0, E_STALL, "sw_rs_after_lw");
    add(1, i_type(OP_SW, 5, 7, 0),              0, E_NONE,  "sw_rs_go");
    add(1, i_type(OP_LW, 1, 6, 0),              0, E_NONE,  "lw6");
    add(1, i_type(OP_SW, 1, 6, 0),              0, E_STALL, "sw_rt_after_lw");
    add(1, i_type(OP_SW, 1, 6, 0),              0, E_NONE,  "sw_rt_go");
    add(1, i_type(OP_LUI, 0, 9, 16'h1234),      0, E_NONE,  "lui9");
    add(1, i_type(OP_BEQ, 9, 1, 4),             0, E_STALL, "beq_after_lui");
    add(1, i_type(OP_BEQ, 9, 1, 4),             0, E_NONE,  "beq_lui_go");
    add(1, i_type(OP_ORI, 1, 12, 7),            0, E_NONE,  "ori12");
    add(1, r_type(FN_ADDU, 12, 12, 13),         0, E_NONE,  "addu_after_alu");
    add(1, r_type(FN_SUBU, 13, 13, 14),         0, E_NONE,  "subu_after_alu");

    foreach (vecs[k]) begin
      step(vecs[k].valid, vecs[k].ins, vecs[k].taken, vecs[k].exp, vecs[k].tag);
    end

    // SYSCALL: flush on the ID cycle, three drain cycles, then sticky halt.
    step(1, sys_i, 0, E_FLUSH, "syscall");
    for (int c = 0; c < 3; c++) step(0, '0, 0, E_DRAIN, $sformatf("drain%0d", c));
    for (int c = 0; c < 20; c++) begin
      step(c[0], jal_i, 1'b1, E_HALT, $sformatf("halt%0d", c));
    end

    // Asynchronous reset while halted.
    #2;
    reset_n = 1'b0;
    #1;
    check_all("reset_in_halt", E_NONE);
    id_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Asynchronous reset mid-cycle while draining.
    step(1, sys_i, 0, E_FLUSH, "syscall2");
    step(0, '0, 0, E_DRAIN, "drain_b0");
    #2;
    reset_n = 1'b0;
    #1;
    check_all("reset_in_drain", E_NONE);
    @(posedge clock);
    @(negedge clock);
    check_all("reset_held", E_NONE);
    reset_n = 1'b1;

    step(1, lw8_i,    0, E_NONE,  "post_reset_lw");
    step(1, addu10_i, 0, E_STALL, "post_reset_addu_stall");
    step(1, addu10_i, 0, E_NONE,  "post_reset_addu_go");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
